// File: rtl/spi_result_framer_pkg.sv
// Shared types and helpers for the SPI result framer: FSM states, blob record
// layout and the 4-byte wire encoding of a record.
package spi_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_REC,
    ST_CHK
  } state_t;

  typedef struct packed {
    logic [2:0]  colour;
    logic [10:0] x;
    logic [10:0] y;
  } blob_rec_t;

  localparam logic [7:0] DEF_SOF       = 8'h5A;
  localparam logic [7:0] DEF_POLL_CMD  = 8'hA5;
  localparam logic [7:0] DEF_FLUSH_CMD = 8'hC3;

  function automatic logic [7:0] rec_byte(input blob_rec_t rec, input logic [1:0] idx);
    case (idx)
      2'd0:    rec_byte = {rec.colour, 2'b00, rec.x[10:8]};
      2'd1:    rec_byte = rec.x[7:0];
      2'd2:    rec_byte = {5'b00000, rec.y[10:8]};
      default: rec_byte = rec.y[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_result_framer_if.sv
// Bundle of the record input, SPI RX/TX Avalon-ST streams and status flags.
// The framer uses the slave view; whatever drives it uses the master view.
interface spi_result_framer_if;

  logic        rec_valid;
  logic [2:0]  rec_colour;
  logic [10:0] rec_x;
  logic [10:0] rec_y;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        busy;

  modport slave (
    input  rec_valid, rec_colour, rec_x, rec_y, rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, overflow, busy
  );

  modport master (
    output rec_valid, rec_colour, rec_x, rec_y, rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, overflow, busy
  );

endinterface

// File: rtl/spi_result_framer_rec_fifo.sv
// Show-ahead FIFO of blob records; head_o is the oldest entry whenever not empty.
module rec_fifo
  import spi_framer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  blob_rec_t                  data_i,
  output blob_rec_t                  head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  blob_rec_t      mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when a pop frees a slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_result_framer.sv
// Buffers blob records and, on a host poll, streams them out as a
// SOF / N / records / XOR-checksum frame over the SPI TX stream.
module spi_result_framer
  import spi_framer_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] POLL_CMD  = DEF_POLL_CMD,
  parameter logic [7:0] FLUSH_CMD = DEF_FLUSH_CMD,
  parameter logic [7:0] SOF       = DEF_SOF
) (
  input logic                clk,
  input logic                reset,
  spi_result_framer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic          ovf_q, ovf_d;

  logic          push, pop, flush;
  logic          tx_valid, rx_ready;
  logic [7:0]    tx_byte;
  blob_rec_t     head, rec_in;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign rec_in = '{colour: bus.rec_colour, x: bus.rec_x, y: bus.rec_y};

  rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (rec_in),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    pop      = 1'b0;
    flush    = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    rx_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (bus.rx_valid && bus.rx_data == POLL_CMD) begin
          // rem_q doubles as the N byte, so it holds the snapshot until CNT.
          rem_d   = fifo_count;
          idx_d   = 2'd0;
          chk_d   = 8'h00;
          state_d = ST_HDR;
        end else if (bus.rx_valid && bus.rx_data == FLUSH_CMD) begin
          flush = 1'b1;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = SOF;
        if (bus.tx_ready) state_d = ST_CNT;
      end
      ST_CNT: begin
        tx_valid = 1'b1;
        tx_byte  = 8'(rem_q);
        if (bus.tx_ready) begin
          chk_d   = chk_q ^ tx_byte;
          state_d = (rem_q == '0) ? ST_CHK : ST_REC;
        end
      end
      ST_REC: begin
        tx_valid = 1'b1;
        tx_byte  = rec_byte(head, idx_q);
        if (bus.tx_ready) begin
          chk_d = chk_q ^ tx_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pop   = !fifo_empty;
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        tx_valid = 1'b1;
        tx_byte  = chk_q;
        if (bus.tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flush in the same cycle as a record discards the record without flagging it.
  assign push  = bus.rec_valid && !flush && (!fifo_full || pop);
  assign ovf_d = flush ? 1'b0 : ((bus.rec_valid && !push) ? 1'b1 : ovf_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= 2'd0;
      chk_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_byte;
  assign bus.rx_ready = rx_ready;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
